pkt_bufid_dispatch: RTL

//  Upstream feeder of the network input process ports: pops free packet-buffer IDs from the shared free-bufid FIFO.

---
 rtl/pkt_bufid_dispatch_pkg.sv | 13 +
 rtl/pkt_bufid_dispatch_bufid_slot.sv | 51 +++++
 rtl/pkt_bufid_dispatch.sv | 93 +++++++++
 3 files changed

// File: rtl/pkt_bufid_dispatch_pkg.sv
// rtl/pkt_bufid_dispatch_pkg.sv - shared widths and slot state encoding for the bufid dispatcher
package pkt_bufid_dispatch_pkg;

    localparam int BUFID_W   = 9;
    localparam int CNT_W     = 16;
    localparam int NUM_PORTS = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HOLD  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/pkt_bufid_dispatch_bufid_slot.sv
// rtl/pkt_bufid_dispatch_bufid_slot.sv - one pre-fetched bufid slot with wr/ack handshake
module bufid_slot
    import pkt_bufid_dispatch_pkg::*;
#(
    parameter int W = BUFID_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         grant_i,
    input  logic         ack_i,
    input  logic [W-1:0] din_i,
    output logic         wr_o,
    output logic [W-1:0] bufid_o,
    output logic         need_o,
    output logic         consume_o
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] bufid_q, bufid_d;

    // A held slot that is acked this cycle can be refilled in the same cycle,
    // so it asks for a bufid just like an empty slot.
    assign need_o    = (state_q == SLOT_EMPTY) || (ack_i && (state_q == SLOT_HOLD));
    assign consume_o = ack_i && (state_q == SLOT_HOLD);
    assign wr_o      = (state_q == SLOT_HOLD);
    assign bufid_o   = bufid_q;

    // Slot state and held bufid register; reset discards any held bufid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SLOT_EMPTY;
            bufid_q <= '0;
        end else begin
            state_q <= state_d;
            bufid_q <= bufid_d;
        end
    end

    // Next state: a grant always (re)loads the slot, otherwise a consumed bufid empties it.
    always_comb begin
        state_d = state_q;
        bufid_d = bufid_q;
        if (grant_i) begin
            state_d = SLOT_HOLD;
            bufid_d = din_i;
        end else if (consume_o) begin
            state_d = SLOT_EMPTY;
        end
    end

endmodule

// File: rtl/pkt_bufid_dispatch.sv
// rtl/pkt_bufid_dispatch.sv - pops free bufids and keeps one pre-fetched bufid per input port
module pkt_bufid_dispatch
    import pkt_bufid_dispatch_pkg::*;
#(
    parameter int BUFID_W_P = BUFID_W,
    parameter int CNT_W_P   = CNT_W
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 i_dispatch_en,
    input  logic [BUFID_W_P-1:0] iv_free_bufid,
    input  logic                 i_free_bufid_empty,
    output logic                 o_free_bufid_rd,
    output logic                 o_pkt_bufid_wr_p0,
    output logic [BUFID_W_P-1:0] ov_pkt_bufid_p0,
    input  logic                 i_pkt_bufid_ack_p0,
    output logic                 o_pkt_bufid_wr_p1,
    output logic [BUFID_W_P-1:0] ov_pkt_bufid_p1,
    input  logic                 i_pkt_bufid_ack_p1,
    output logic                 o_bufid_starve_pulse,
    output logic [CNT_W_P-1:0]   ov_dispatch_cnt,
    output logic [1:0]           ov_slot_state
);

    logic               need0, need1;
    logic               consume0, consume1;
    logic               grant0, grant1;
    logic               can_pop, contended, starved;
    logic               rr_q, rr_d;
    logic               starved_d1_q;
    logic               starve_pulse_q;
    logic [CNT_W_P-1:0] cnt_q, cnt_d;

    // Pops are suppressed during reset so no bufid is taken into a slot that is being cleared.
    assign can_pop   = i_dispatch_en && !i_free_bufid_empty && !reset;
    assign contended = need0 && need1;

    // rr_q = 0 favours port0 on contention; it only moves when a contended grant is made.
    assign grant0 = can_pop && need0 && (!need1 || !rr_q);
    assign grant1 = can_pop && need1 && (!need0 ||  rr_q);
    assign rr_d   = (can_pop && contended) ? !rr_q : rr_q;

    assign o_free_bufid_rd = grant0 || grant1;

    assign starved = (need0 || need1) && i_free_bufid_empty && i_dispatch_en;

    assign cnt_d = cnt_q + {{(CNT_W_P-1){1'b0}}, consume0}
                         + {{(CNT_W_P-1){1'b0}}, consume1};

    bufid_slot #(.W(BUFID_W_P)) u_slot0 (
        .clk_i     (clk_sys),
        .reset_i   (reset),
        .grant_i   (grant0),
        .ack_i     (i_pkt_bufid_ack_p0),
        .din_i     (iv_free_bufid),
        .wr_o      (o_pkt_bufid_wr_p0),
        .bufid_o   (ov_pkt_bufid_p0),
        .need_o    (need0),
        .consume_o (consume0)
    );

    bufid_slot #(.W(BUFID_W_P)) u_slot1 (
        .clk_i     (clk_sys),
        .reset_i   (reset),
        .grant_i   (grant1),
        .ack_i     (i_pkt_bufid_ack_p1),
        .din_i     (iv_free_bufid),
        .wr_o      (o_pkt_bufid_wr_p1),
        .bufid_o   (ov_pkt_bufid_p1),
        .need_o    (need1),
        .consume_o (consume1)
    );

    assign ov_slot_state        = {o_pkt_bufid_wr_p1, o_pkt_bufid_wr_p0};
    assign o_bufid_starve_pulse = starve_pulse_q;
    assign ov_dispatch_cnt      = cnt_q;

    // Arbiter pointer, starvation edge detector and delivered-bufid counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rr_q           <= 1'b0;
            starved_d1_q   <= 1'b0;
            starve_pulse_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            rr_q           <= rr_d;
            starved_d1_q   <= starved;
            starve_pulse_q <= starved && !starved_d1_q;
            cnt_q          <= cnt_d;
        end
    end

endmodule
